// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the row-fetch FSM state type, used by the
// row fetcher and the display stage.
package vga_pkg;

  localparam int unsigned HPIXELS   = 800;
  localparam int unsigned VLINES    = 525;
  localparam int unsigned HACTIVE   = 640;
  localparam int unsigned VACTIVE   = 480;
  localparam int unsigned ROW_LINES = 20;
  localparam int unsigned NROWS     = VACTIVE / ROW_LINES;

  localparam int unsigned HC_W   = 10;
  localparam int unsigned VC_W   = 10;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned LIR_W  = 5;
  localparam int unsigned WORD_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } fetch_state_t;

  // One lit column per row, walking right and repeating every 8 rows.
  function automatic logic [WORD_W-1:0] test_pattern_word(input logic [2:0] row_lsb);
    logic [7:0] col;
    col = 8'h80 >> row_lsb;
    return {col, 56'h0};
  endfunction

endpackage

// File: rtl/vga_scan_counter.sv
// Horizontal/vertical scan counters plus line-in-row and row counters that
// describe the NEXT scan line, so fetch logic can look one line ahead.
module vga_scan_counter
  import vga_pkg::*;
#(
  parameter int unsigned P_HPIXELS   = HPIXELS,
  parameter int unsigned P_VLINES    = VLINES,
  parameter int unsigned P_ROW_LINES = ROW_LINES
) (
  input  logic             dclk,
  input  logic             clr,
  output logic [HC_W-1:0]  o_hc,
  output logic [VC_W-1:0]  o_vc,
  output logic [LIR_W-1:0] o_nlir,
  output logic [ROW_W-1:0] o_nrow
);

  logic [HC_W-1:0]  r_hc;
  logic [VC_W-1:0]  r_vc;
  logic [LIR_W-1:0] r_nlir;
  logic [ROW_W-1:0] r_nrow;
  logic             w_h_end;
  logic             w_v_end;
  logic             w_nv_wrap;

  assign w_h_end   = (r_hc == HC_W'(P_HPIXELS - 1));
  assign w_v_end   = (r_vc == VC_W'(P_VLINES - 1));
  assign w_nv_wrap = (r_vc == VC_W'(P_VLINES - 2));

  // After reset vc=0, so the next line is 1: line 1 of row 0.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      r_hc   <= '0;
      r_vc   <= '0;
      r_nlir <= LIR_W'(1);
      r_nrow <= '0;
    end else if (w_h_end) begin
      r_hc <= '0;
      r_vc <= w_v_end ? '0 : r_vc + VC_W'(1);
      if (w_v_end) begin
        r_nlir <= LIR_W'(1);
        r_nrow <= '0;
      end else if (w_nv_wrap) begin
        r_nlir <= '0;
        r_nrow <= '0;
      end else if (r_nlir == LIR_W'(P_ROW_LINES - 1)) begin
        r_nlir <= '0;
        r_nrow <= r_nrow + ROW_W'(1);
      end else begin
        r_nlir <= r_nlir + LIR_W'(1);
      end
    end else begin
      r_hc <= r_hc + HC_W'(1);
    end
  end

  assign o_hc   = r_hc;
  assign o_vc   = r_vc;
  assign o_nlir = r_nlir;
  assign o_nrow = r_nrow;

endmodule

// File: rtl/vga_row_fetch.sv
// Fetches the next row word during horizontal blanking and commits it to vdata
// at the line boundary. VGA_ROW_FETCH_TEST_PATTERN_EN replaces memory with a diagonal.
module vga_row_fetch
  import vga_pkg::*;
#(
  parameter int unsigned P_HPIXELS   = HPIXELS,
  parameter int unsigned P_VLINES    = VLINES,
  parameter int unsigned P_HACTIVE   = HACTIVE,
  parameter int unsigned P_VACTIVE   = VACTIVE,
  parameter int unsigned P_ROW_LINES = ROW_LINES
) (
  input  logic              dclk,
  input  logic              clr,
  output logic              mem_req,
  output logic [ROW_W-1:0]  mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] vdata,
  output logic              underrun
);

  localparam int unsigned P_NROWS = P_VACTIVE / P_ROW_LINES;

  logic [HC_W-1:0]   w_hc;
  logic [VC_W-1:0]   w_vc;
  logic [LIR_W-1:0]  w_nlir;
  logic [ROW_W-1:0]  w_nrow;
  logic              w_trigger;
  logic              w_commit;
  logic              w_unused_vc;

  fetch_state_t      r_state;
  logic              r_mem_req;
  logic [ROW_W-1:0]  r_mem_addr;
  logic [WORD_W-1:0] r_shadow;
  logic [WORD_W-1:0] r_vdata;
  logic              r_underrun;

  fetch_state_t      w_state_nxt;
  logic              w_mem_req_nxt;
  logic [ROW_W-1:0]  w_mem_addr_nxt;
  logic [WORD_W-1:0] w_shadow_nxt;
  logic [WORD_W-1:0] w_vdata_nxt;
  logic              w_underrun_nxt;

  vga_scan_counter #(
    .P_HPIXELS   (P_HPIXELS),
    .P_VLINES    (P_VLINES),
    .P_ROW_LINES (P_ROW_LINES)
  ) u_scan (
    .dclk   (dclk),
    .clr    (clr),
    .o_hc   (w_hc),
    .o_vc   (w_vc),
    .o_nlir (w_nlir),
    .o_nrow (w_nrow)
  );

  assign w_unused_vc = ^w_vc;

  // Next line starts a visible row: launch its fetch at the start of blanking.
  assign w_trigger = (w_hc == HC_W'(P_HACTIVE)) && (w_nlir == '0) &&
                     (w_nrow < ROW_W'(P_NROWS));
  assign w_commit  = (w_hc == HC_W'(P_HPIXELS - 1));

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_shadow   <= '0;
      r_vdata    <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_shadow   <= w_shadow_nxt;
      r_vdata    <= w_vdata_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_shadow_nxt   = r_shadow;
    w_vdata_nxt    = r_vdata;
    w_underrun_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trigger) begin
`ifdef VGA_ROW_FETCH_TEST_PATTERN_EN
          w_shadow_nxt   = test_pattern_word(w_nrow[2:0]);
          w_state_nxt    = FULL;
`else
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = w_nrow;
          w_state_nxt    = REQ;
`endif
        end
      end
      REQ: begin
        if (mem_ack) begin
          w_shadow_nxt  = mem_rdata;
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = FULL;
        end
        // Late word: keep the old line's data, flag it, commit on the next boundary.
        if (w_commit) begin
          w_underrun_nxt = 1'b1;
        end
      end
      FULL: begin
        if (w_commit) begin
          w_vdata_nxt = r_shadow;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign vdata    = r_vdata;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_vga_row_fetch.sv
// Self-checking bench for vga_row_fetch on scaled-down timing, against a
// schedule-based reference model of request, commit and underrun times.
module tb_vga_row_fetch;

  localparam int HP   = 120;
  localparam int VL   = 40;
  localparam int HA   = 80;
  localparam int VA   = 32;
  localparam int RL   = 4;
  localparam int NR   = VA / RL;
  localparam int NF   = 3;
  localparam int LMAX = HP - 2 - (HA + 1);
`ifdef VGA_ROW_FETCH_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic        dclk = 1'b0;
  logic        clr  = 1'b1;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        mem_req;
  logic [4:0]  mem_addr;
  logic [63:0] vdata;
  logic        underrun;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat  [NF+1][NR];
  logic [63:0] word [NF+1][NR];

  vga_row_fetch #(
    .P_HPIXELS   (HP),
    .P_VLINES    (VL),
    .P_HACTIVE   (HA),
    .P_VACTIVE   (VA),
    .P_ROW_LINES (RL)
  ) dut (
    .dclk      (dclk),
    .clr       (clr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .vdata     (vdata),
    .underrun  (underrun)
  );

  always #5 dclk = ~dclk;

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Expected outputs during cycle k (k edges after reset release), and the
  // memory response scheduled for that cycle.
  task automatic model(input int k, output logic er, output logic [4:0] ea,
                       output logic [63:0] ev, output logic eu,
                       output logic eack, output logic [63:0] erd);
    int best, line, rs, ack, cm;
    bit late;
    logic [7:0] col;
    best = -1;
    er = 1'b0; ea = '0; ev = '0; eu = 1'b0; eack = 1'b0; erd = '0;
    for (int f = 0; f <= NF; f++) begin
      for (int r = 0; r < NR; r++) begin
        if (f == 0 && r == 0) continue;
        line = (r == 0) ? f * VL - 1 : f * VL + r * RL - 1;
        rs   = line * HP + HA + 1;
        ack  = rs + (PAT ? 0 : lat[f][r]);
        late = !PAT && (ack > line * HP + HP - 2);
        cm   = (line + (late ? 2 : 1)) * HP;
        if (!PAT && k >= rs && k <= ack) begin
          er = 1'b1;
          ea = 5'(r);
        end
        if (!PAT && k == ack) begin
          eack = 1'b1;
          erd  = word[f][r];
        end
        if (late && k == (line + 1) * HP) eu = 1'b1;
        if (k >= cm && cm > best) begin
          best = cm;
          col  = 8'h80 >> (r % 8);
          ev   = PAT ? {col, 56'h0} : word[f][r];
        end
      end
    end
  endtask

  task automatic chk_zero(input string tag, input int k);
    chk({tag, "_mem_req"}, k, 64'(mem_req), 64'd0);
    chk({tag, "_mem_addr"}, k, 64'(mem_addr), 64'd0);
    chk({tag, "_vdata"}, k, vdata, 64'd0);
    chk({tag, "_underrun"}, k, 64'(underrun), 64'd0);
  endtask

  // Called at posedge+1 with clr just released; runs and checks cycles 0..kmax.
  task automatic run(input int kmax);
    logic er, eu, eack;
    logic [4:0] ea;
    logic [63:0] ev, erd;
    for (int k = 0; k <= kmax; k++) begin
      if (k > 0) begin
        @(posedge dclk);
        #1;
      end
      model(k, er, ea, ev, eu, eack, erd);
      chk("mem_req", k, 64'(mem_req), 64'(er));
      if (er) chk("mem_addr", k, 64'(mem_addr), 64'(ea));
      chk("vdata", k, vdata, ev);
      chk("underrun", k, 64'(underrun), 64'(eu));
      mem_ack   = eack || (!er && ($urandom_range(0, 15) == 0));
      mem_rdata = eack ? erd : {$urandom, $urandom};
    end
  endtask

  initial begin
    for (int f = 0; f <= NF; f++) begin
      for (int r = 0; r < NR; r++) begin
        lat[f][r]  = $urandom_range(0, LMAX);
        word[f][r] = (f == 0) ? 64'(r) * 64'h0101010101010101 : {$urandom, $urandom};
      end
    end
    lat[0][1]  = 0;
    lat[0][2]  = LMAX;
    lat[0][3]  = LMAX + 1;
    lat[0][5]  = 60;
    lat[1][0]  = LMAX + 5;
    lat[2][0]  = 0;
    lat[NF][1] = 100;

    // Reset holds everything at zero even with acks arriving.
    #12;
    chk_zero("reset", -1);
    mem_ack   = 1'b1;
    mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    repeat (3) begin
      @(posedge dclk);
      #1;
      chk_zero("reset_ack", -1);
    end
    mem_ack = 1'b0;
    clr     = 1'b0;
    run((NF * VL + RL - 1) * HP + HA + 1 + 50);

    // Mid-fetch reset must drop the request without waiting for a clock edge.
    #2;
    clr = 1'b1;
    #1;
    chk_zero("async_clr", -1);
    mem_ack   = 1'b1;
    mem_rdata = {$urandom, $urandom};
    repeat (3) begin
      @(posedge dclk);
      #1;
      chk_zero("clr_hold", -1);
    end
    mem_ack = 1'b0;
    clr     = 1'b0;
    run((VL + 6) * HP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
